offload_src_gen: RTL and testbench
==================================

OFFLOAD_SRC_GEN -- requirements
Module: offload_src_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning stream width in bits, a multiple of 16.
REQ-002 SHALL have parameter LENGTH_WIDTH, default 16, meaning width of the programmed beat count.
REQ-003 SHALL have port clk  input  1  the single clock; every signal is synchronous to it.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-006 SHALL have port length  input  LENGTH_WIDTH  transfer length in beats minus 1, sampled when start is accepted.
REQ-007 SHALL have port sync_en  input  1  when 1, streaming waits for sync_ext; sampled when start is accepted.
REQ-008 SHALL have port sync_ext  input  1  external synchronisation strobe.
REQ-009 SHALL have port init_req  output  1  marks an offload write session in progress.
REQ-010 SHALL have port m_axis_valid  output  1  stream valid, wired to the offload src_valid.
REQ-011 SHALL have port m_axis_ready  input  1  stream ready.
REQ-012 SHALL have port m_axis_data  output  DATA_WIDTH  stream data.
REQ-013 SHALL have port m_axis_last  output  1  final beat of the transfer.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the transfer completes.

Function
REQ-016 SHALL implement states IDLE, WAIT_SYNC, STREAM and DONE.
REQ-017 In IDLE, start=1 SHALL latch length and sync_en, clear the beat counter, and go to WAIT_SYNC if sync_en=1, else to STREAM.
REQ-018 SHALL ignore start in all states other than IDLE.
REQ-019 In WAIT_SYNC, sync_ext=1 SHALL cause a transition to STREAM on the next edge; sync_ext SHALL be ignored in all other states.
REQ-020 init_req SHALL be 1 in WAIT_SYNC and STREAM and 0 in IDLE and DONE (registered, asserted the cycle after start is accepted).
REQ-021 m_axis_valid SHALL be 1 throughout STREAM and 0 in all other states.
REQ-022 Once asserted, m_axis_valid, m_axis_data and m_axis_last SHALL hold stable until m_axis_ready=1.
REQ-023 A beat SHALL transfer on any cycle with valid=1 and ready=1; the beat counter SHALL then increment by 1.
REQ-024 For beat n (0-based), 16-bit lane i SHALL carry (n*(DATA_WIDTH/16)+i) mod 65536, lane 0 in the LSBs, with wrap-around at 65536.
REQ-025 m_axis_last SHALL be 1 exactly when beat counter equals the latched length.
REQ-026 A transfer of the last beat SHALL move to DONE; DONE SHALL assert done for one cycle and return to IDLE on the next edge.
REQ-027 length=0 SHALL produce a single beat with last=1.
REQ-028 length=2^LENGTH_WIDTH-1 SHALL produce 2^LENGTH_WIDTH beats without counter overflow before last.
REQ-029 A new start SHALL be accepted at the earliest in the cycle after done, i.e. once back in IDLE.
REQ-030 Throughput SHALL be one beat per cycle while ready=1; first valid SHALL appear one cycle after entering STREAM or fewer.

Reset
REQ-031 rst=1 SHALL force IDLE and set init_req, m_axis_valid, m_axis_last, busy and done to 0, and set m_axis_data and the beat counter to 0.
REQ-032 rst asserted mid-transfer SHALL abort at once with no further beats and no done pulse.
REQ-033 rst SHALL take priority over start and sync_ext in the same cycle.

Verification
REQ-034 start, length=3, sync_en=0, ready=1 -> 4 consecutive beats, lane0 = 0,4,8,12 (DATA_WIDTH=64), last on beat 3, done 1 cycle later, init_req low after.
REQ-035 start, sync_en=1, sync_ext held 0 for 20 cycles then pulsed -> init_req=1 and valid=0 for those 20 cycles, streaming begins after the pulse.
REQ-036 length=7, ready toggling pseudo-randomly -> exactly 8 beats in order, data/last stable while stalled, no dropped or duplicated beat.
REQ-037 length=0 -> one beat, data 0x0003_0002_0001_0000, last=1, done pulse.
REQ-038 rst=1 at beat 2 of length=9 -> next cycle valid=0, init_req=0, busy=0, no done; a fresh start restarts data at 0.
REQ-039 length=16383 with DATA_WIDTH=64 -> lane0 wraps from 65532 to 0 at beat 16384/… boundary (beat 16383 lane3=65535), last on beat 16383.

Source files
------------

// File: rtl/offload_src_gen.sv
// Offload source generator: emits a counting 16-bit-lane stream of a
// programmed beat count, optionally gated on an external sync strobe.
module offload_src_gen #(
  parameter int DATA_WIDTH   = 64,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LENGTH_WIDTH-1:0] length,
  input  logic                    sync_en,
  input  logic                    sync_ext,
  output logic                    init_req,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_data,
  output logic                    m_axis_last,
  output logic                    busy,
  output logic                    done
);

  localparam int LANES = DATA_WIDTH / 16;
  localparam int PW    = LENGTH_WIDTH + 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    STREAM    = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LENGTH_WIDTH-1:0] r_cnt;
  logic [LENGTH_WIDTH-1:0] r_len;
  logic                    r_sync;

  logic                    w_accept;
  logic                    w_beat;
  logic                    w_last;
  logic [PW-1:0]           w_prod;
  logic [15:0]             w_base;
  logic [DATA_WIDTH-1:0]   w_data;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_cnt == r_len);
  assign w_beat   = (r_state == STREAM) && m_axis_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = sync_en ? WAIT_SYNC : STREAM;
      end
      WAIT_SYNC: begin
        if (sync_ext || !r_sync) w_next = STREAM;
      end
      STREAM: begin
        if (m_axis_ready && w_last) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sync  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt  <= '0;
        r_len  <= length;
        r_sync <= sync_en;
      end else if (w_beat && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Lane values are taken modulo 65536, so only the low 16 product bits matter.
  assign w_prod = PW'(r_cnt) * PW'(LANES);
  assign w_base = w_prod[15:0];

  always_comb begin
    w_data = '0;
    for (int i = 0; i < LANES; i++) begin
      w_data[16*i +: 16] = w_base + 16'(i);
    end
  end

  assign m_axis_valid = (r_state == STREAM);
  assign m_axis_data  = m_axis_valid ? w_data : '0;
  assign m_axis_last  = m_axis_valid && w_last;
  assign init_req     = (r_state == WAIT_SYNC) || (r_state == STREAM);
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);

endmodule

// File: tb/tb_offload_src_gen.sv
// Directed self-checking bench for offload_src_gen (DATA_WIDTH=64).
module tb_offload_src_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] length;
  logic        sync_en;
  logic        sync_ext;
  logic        init_req;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic [63:0] m_axis_data;
  logic        m_axis_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  offload_src_gen #(.DATA_WIDTH(64), .LENGTH_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .length       (length),
    .sync_en      (sync_en),
    .sync_ext     (sync_ext),
    .init_req     (init_req),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_last  (m_axis_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_data(input int n);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = 16'(n * 4 + i);
    return r;
  endfunction

  task automatic drain_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    length = 16'd5;
    sync_ext = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({init_req, m_axis_valid, m_axis_last, busy, done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000",
        {init_req, m_axis_valid, m_axis_last, busy, done});
    end
    total++;
    if (m_axis_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", m_axis_data);
    end
    rst = 1'b0;
    start = 1'b0;
    sync_ext = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] lane0 [4];
    lane0 = '{16'd0, 16'd4, 16'd8, 16'd12};
    m_axis_ready = 1'b1;
    start = 1'b1;
    length = 16'd3;
    sync_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      total++;
      if (m_axis_valid !== 1'b1 || init_req !== 1'b1) begin
        bad++;
        $display("FAIL basic_valid%0d: valid=%b init=%b want 1 1",
          b, m_axis_valid, init_req);
      end
      total++;
      if (m_axis_data[15:0] !== lane0[b]) begin
        bad++;
        $display("FAIL basic_lane0_%0d: got %0d want %0d",
          b, m_axis_data[15:0], lane0[b]);
      end
      total++;
      if (m_axis_last !== (b == 3)) begin
        bad++;
        $display("FAIL basic_last%0d: got %b want %b",
          b, m_axis_last, (b == 3));
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || m_axis_valid !== 1'b0 || init_req !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: done=%b valid=%b init=%b want 1 0 0",
        done, m_axis_valid, init_req);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_after: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_sync();
    int errs;
    errs = 0;
    m_axis_ready = 1'b1;
    start = 1'b1;
    length = 16'd1;
    sync_en = 1'b1;
    @(negedge clk);
    // A second start while waiting must not reprogram the length.
    length = 16'd0;
    for (int i = 0; i < 20; i++) begin
      if (init_req !== 1'b1 || m_axis_valid !== 1'b0) errs++;
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL sync_wait: %0d bad cycles want 0", errs);
    end
    sync_ext = 1'b1;
    @(negedge clk);
    sync_ext = 1'b0;
    total++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== exp_data(0)
        || m_axis_last !== 1'b0) begin
      bad++;
      $display("FAIL sync_beat0: valid=%b data=%h last=%b",
        m_axis_valid, m_axis_data, m_axis_last);
    end
    @(negedge clk);
    total++;
    if (m_axis_data !== exp_data(1) || m_axis_last !== 1'b1) begin
      bad++;
      $display("FAIL sync_beat1: data=%h last=%b want %h 1",
        m_axis_data, m_axis_last, exp_data(1));
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL sync_done: got %b want 1", done);
    end
    sync_en = 1'b0;
    drain_idle("sync");
  endtask

  task automatic test_stall();
    logic [31:0] pat;
    int nb;
    int errs;
    bit seen_done;
    pat = 32'b1011_0010_1101_0011_1001_0110_1110_0101;
    nb = 0;
    errs = 0;
    seen_done = 0;
    m_axis_ready = 1'b0;
    start = 1'b1;
    length = 16'd7;
    sync_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      if (done) begin
        seen_done = 1;
      end else begin
        if (m_axis_valid) begin
          if (m_axis_data !== exp_data(nb) || m_axis_last !== (nb == 7))
            errs++;
        end
        m_axis_ready = pat[c % 32];
        if (m_axis_valid && m_axis_ready) nb++;
        @(negedge clk);
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stall_data: %0d bad beats want 0", errs);
    end
    total++;
    if (nb != 8 || !seen_done) begin
      bad++;
      $display("FAIL stall_count: beats=%0d done=%0d want 8 1", nb, seen_done);
    end
    m_axis_ready = 1'b1;
    drain_idle("stall");
  endtask

  task automatic test_len0();
    m_axis_ready = 1'b1;
    start = 1'b1;
    length = 16'd0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (m_axis_valid !== 1'b1 || m_axis_last !== 1'b1
        || m_axis_data !== 64'h0003_0002_0001_0000) begin
      bad++;
      $display("FAIL len0_beat: valid=%b last=%b data=%h",
        m_axis_valid, m_axis_last, m_axis_data);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || m_axis_valid !== 1'b0) begin
      bad++;
      $display("FAIL len0_done: done=%b valid=%b want 1 0", done, m_axis_valid);
    end
    drain_idle("len0");
  endtask

  task automatic test_abort();
    int dn;
    dn = 0;
    m_axis_ready = 1'b1;
    start = 1'b1;
    length = 16'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (m_axis_data !== exp_data(2)) begin
      bad++;
      $display("FAIL abort_beat2: got %h want %h", m_axis_data, exp_data(2));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({m_axis_valid, init_req, busy, done} !== 4'b0
        || m_axis_data !== 64'h0) begin
      bad++;
      $display("FAIL abort_state: v/i/b/d=%b data=%h want 0000 0",
        {m_axis_valid, init_req, busy, done}, m_axis_data);
    end
    for (int i = 0; i < 12; i++) begin
      if (done || m_axis_valid) dn++;
      @(negedge clk);
    end
    total++;
    if (dn != 0) begin
      bad++;
      $display("FAIL abort_quiet: %0d active cycles want 0", dn);
    end
    start = 1'b1;
    length = 16'd1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (m_axis_data !== 64'h0003_0002_0001_0000 || m_axis_last !== 1'b0) begin
      bad++;
      $display("FAIL abort_restart: data=%h last=%b", m_axis_data, m_axis_last);
    end
    drain_idle("abort");
  endtask

  task automatic test_wrap();
    int errs;
    m_axis_ready = 1'b1;
    errs = 0;
    start = 1'b1;
    length = 16'd16383;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 16384; b++) begin
      if (m_axis_valid !== 1'b1 || m_axis_data !== exp_data(b)
          || m_axis_last !== (b == 16383)) begin
        if (errs < 4)
          $display("FAIL wrap_beat%0d: data=%h last=%b want %h %b", b,
            m_axis_data, m_axis_last, exp_data(b), (b == 16383));
        errs++;
      end
      if (b == 16383) begin
        total++;
        if (m_axis_data !== 64'hFFFF_FFFE_FFFD_FFFC) begin
          bad++;
          $display("FAIL wrap_final: got %h want fffffffefffdfffc",
            m_axis_data);
        end
      end
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL wrap_stream: %0d bad beats want 0", errs);
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL wrap_done: got %b want 1", done);
    end
    drain_idle("wrap");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    length = '0;
    sync_en = 1'b0;
    sync_ext = 1'b0;
    m_axis_ready = 1'b0;
    test_reset();
    test_basic();
    test_sync();
    test_stall();
    test_len0();
    test_abort();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
